axi4lite_regbank: RTL and testbench
===================================

Name: axi4lite_regbank

Overview:
- AXI4-Lite slave register bank: consumes write/read transactions issued on the team's AXI4-Lite master bus and terminates them in NREG 32-bit control registers.
- Register contents are exported flat to the design, with a per-register write-strobe pulse.
- Sits directly downstream of the AXI4-Lite interface; its port set matches that interface's slave modport one-to-one.

Parameters:
- AW, 32, address width of awaddr/araddr
- NREG, 8, number of 32-bit registers; power of two, 2..256

Ports:
- clk  input  1  clock; all logic rising-edge
- reset  input  1  synchronous, active-high reset
- awaddr  input  AW  write address
- awprot  input  3  write protection; accepted, ignored
- awvalid  input  1  write address valid
- awready  output  1  write address ready
- wdata  input  32  write data
- wstrb  input  4  byte-lane write strobes
- wvalid  input  1  write data valid
- wready  output  1  write data ready
- bresp  output  2  write response
- bvalid  output  1  write response valid
- bready  input  1  write response ready
- araddr  input  AW  read address
- arprot  input  3  read protection; accepted, ignored
- arvalid  input  1  read address valid
- arready  output  1  read address ready
- rdata  output  32  read data
- rresp  output  2  read response
- rvalid  output  1  read data valid
- rready  input  1  read data ready
- reg_q  output  NREG*32  register contents; register i is reg_q[32*i +: 32]
- wr_pulse  output  NREG  one-cycle pulse on the cycle after register i is written

Behaviour:
- Reset: all registers = 0, reg_q = 0, wr_pulse = 0, bvalid = rvalid = 0, bresp = rresp = 0, rdata = 0, aw/w holding latches empty. awready = wready = arready = 1 in the first cycle after reset deasserts.
- Decode:
  - Word index = addr[2 +: log2(NREG)].
  - In range when addr < NREG*4.
  - addr[1:0] ignored.
- Write channel, independent AW and W holding latches:
  - awready = !aw_held && !bvalid.
  - wready = !w_held && !bvalid.
  - An AW or W handshake fills its latch. AW and W may arrive in either order, any cycles apart.
  - Commit cycle: both are available (latched or handshaking this cycle) and bvalid = 0.
  - At the commit edge: in-range register bytes with wstrb[k] = 1 take wdata[8k+7:8k]; both latches clear; bvalid = 1 and wr_pulse[idx] = 1 (in-range only) from the next cycle.
  - Minimum latency: AW+W handshake in cycle N -> reg_q updated and bvalid high in cycle N+1.
- B channel:
  - bvalid holds, with bresp stable, until bvalid && bready. It then drops the next cycle.
  - AW/W ready stay low while bvalid = 1.
  - Throughput with bready tied high: one write per 2 cycles.
- Read channel:
  - arready = !rvalid.
  - On the AR handshake edge: rdata = register[idx], or 0 if out of range; rvalid = 1 next cycle.
  - rdata/rresp held stable until rvalid && rready. rvalid then drops; arready returns high the following cycle.
- Responses: OKAY (2'b00) everywhere, except as modified by the optional feature.
- Simultaneous read and write of the same register on the same edge: the read returns the pre-write value.
- Write and read paths are fully independent; they never stall each other.
- wstrb = 4'b0000 commits: registers unchanged, bvalid asserted, wr_pulse still fires.
- Reset asserted mid-transaction: all latches, pending responses and registers cleared next edge. In-flight transactions are dropped with no response.

Optional Feature:
- Macro: AXI4LITE_REGBANK_SLVERR_EN
- Defined: out-of-range write -> no register change, no wr_pulse, bresp = 2'b10 (SLVERR). Out-of-range read -> rdata = 0, rresp = 2'b10.
- Undefined: out-of-range write silently ignored with bresp = 2'b00; out-of-range read returns rdata = 0, rresp = 2'b00. No SLVERR logic is built.

Test Plan:
- Reset, then write 0xDEADBEEF to 0x04 with AW and W in the same cycle, bready = 1 -> bvalid in cycle N+1, bresp = 00, reg_q[63:32] = 0xDEADBEEF, wr_pulse = 8'b0000_0010 for one cycle.
- W issued 3 cycles before AW, address 0x08, wstrb = 4'b0101, data 0x11223344, reg previously 0xFFFFFFFF -> reg becomes 0xFF22FF44; exactly one bvalid.
- bready held low 5 cycles after a write -> bvalid and bresp stable for 5 cycles, awready = wready = 0 throughout; a second AW offered meanwhile is not accepted until after the B handshake.
- Read 0x04 with rready low 3 cycles, then high -> rdata = 0xDEADBEEF held stable, arready low until 1 cycle after the R handshake.
- Same-edge AR and AW+W to 0x0C (old 0x0, new 0x5A5A5A5A) -> rdata = 0x0, subsequent read returns 0x5A5A5A5A.
- Access address 0x40 with NREG = 8 -> with AXI4LITE_REGBANK_SLVERR_EN: bresp = rresp = 2'b10, rdata = 0, no register or wr_pulse change; without the macro: responses 2'b00, same data behaviour.

Source files
------------

// File: rtl/axi4lite_regbank.sv
// axi4lite_regbank: AXI4-Lite slave terminating in NREG flat-exported registers; SLVERR on out-of-range access when AXI4LITE_REGBANK_SLVERR_EN is defined
module axi4lite_regbank #(
    parameter int AW   = 32,
    parameter int NREG = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [AW-1:0]      awaddr,
    input  logic [2:0]         awprot,
    input  logic               awvalid,
    output logic               awready,
    input  logic [31:0]        wdata,
    input  logic [3:0]         wstrb,
    input  logic               wvalid,
    output logic               wready,
    output logic [1:0]         bresp,
    output logic               bvalid,
    input  logic               bready,
    input  logic [AW-1:0]      araddr,
    input  logic [2:0]         arprot,
    input  logic               arvalid,
    output logic               arready,
    output logic [31:0]        rdata,
    output logic [1:0]         rresp,
    output logic               rvalid,
    input  logic               rready,
    output logic [NREG*32-1:0] reg_q,
    output logic [NREG-1:0]    wr_pulse
);
    localparam int LW = $clog2(NREG);
    logic               aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic               bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [AW-1:0]      aw_addr_q, aw_addr_d;
    logic [31:0]        w_data_q, w_data_d, rdata_q, rdata_d;
    logic [3:0]         w_strb_q, w_strb_d;
    logic [1:0]         bresp_q, bresp_d, rresp_q, rresp_d, wr_err, rd_err;
    logic [NREG*32-1:0] reg_d;
    logic [NREG-1:0]    wr_pulse_q, wr_pulse_d;
    logic               aw_hs, w_hs, ar_hs, commit, win, rin;
    logic [AW-1:0]      waddr;
    logic [31:0]        wd;
    logic [3:0]         ws;
    logic [LW-1:0]      widx, ridx;

    assign awready  = !aw_held_q && !bvalid_q;
    assign wready   = !w_held_q && !bvalid_q;
    assign arready  = !rvalid_q;
    assign aw_hs    = awvalid && awready;
    assign w_hs     = wvalid && wready;
    assign ar_hs    = arvalid && arready;
    assign commit   = (aw_held_q || aw_hs) && (w_held_q || w_hs) && !bvalid_q;
    assign waddr    = aw_held_q ? aw_addr_q : awaddr;
    assign wd       = w_held_q ? w_data_q : wdata;
    assign ws       = w_held_q ? w_strb_q : wstrb;
    assign win      = waddr < AW'(NREG * 4);
    assign rin      = araddr < AW'(NREG * 4);
    assign widx     = waddr[2 +: LW];
    assign ridx     = araddr[2 +: LW];
    assign bvalid   = bvalid_q;
    assign bresp    = bresp_q;
    assign rvalid   = rvalid_q;
    assign rdata    = rdata_q;
    assign rresp    = rresp_q;
    assign wr_pulse = wr_pulse_q;

`ifdef AXI4LITE_REGBANK_SLVERR_EN
    assign wr_err = win ? 2'b00 : 2'b10;
    assign rd_err = rin ? 2'b00 : 2'b10;
`else
    assign wr_err = 2'b00;
    assign rd_err = 2'b00;
`endif

    always_comb begin
        aw_held_d  = !commit && (aw_held_q || aw_hs);
        w_held_d   = !commit && (w_held_q || w_hs);
        aw_addr_d  = aw_hs ? awaddr : aw_addr_q;
        w_data_d   = w_hs ? wdata : w_data_q;
        w_strb_d   = w_hs ? wstrb : w_strb_q;
        bvalid_d   = commit || (bvalid_q && !bready);
        bresp_d    = commit ? wr_err : bresp_q;
        wr_pulse_d = (commit && win) ? NREG'(1) << widx : '0;
        reg_d      = reg_q;
        for (int k = 0; k < 4; k++)
            if (commit && win && ws[k]) reg_d[32*widx + 8*k +: 8] = wd[8*k +: 8];
        // reads sample reg_q, so a same-edge write is not visible yet
        rvalid_d   = ar_hs || (rvalid_q && !rready);
        rdata_d    = ar_hs ? (rin ? reg_q[32*ridx +: 32] : 32'h0) : rdata_q;
        rresp_d    = ar_hs ? rd_err : rresp_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            aw_addr_q  <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= '0;
            wr_pulse_q <= '0;
            reg_q      <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= '0;
        end else begin
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            aw_addr_q  <= aw_addr_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            wr_pulse_q <= wr_pulse_d;
            reg_q      <= reg_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end
endmodule

// File: tb/tb_axi4lite_regbank.sv
// tb_axi4lite_regbank: directed checks of the register bank; error responses follow AXI4LITE_REGBANK_SLVERR_EN
module tb_axi4lite_regbank;
    logic         clk = 0, reset = 1;
    logic [31:0]  awaddr = 0, araddr = 0, wdata = 0;
    logic [2:0]   awprot = 0, arprot = 0;
    logic [3:0]   wstrb = 0;
    logic         awvalid = 0, wvalid = 0, bready = 1, arvalid = 0, rready = 1;
    logic         awready, wready, bvalid, arready, rvalid;
    logic [1:0]   bresp, rresp;
    logic [31:0]  rdata;
    logic [255:0] reg_q, exp_q = '0;
    logic [7:0]   wr_pulse;
    int           errs = 0, nchk = 0, nb;
`ifdef AXI4LITE_REGBANK_SLVERR_EN
    localparam logic [1:0] ERR = 2'b10;
`else
    localparam logic [1:0] ERR = 2'b00;
`endif

    axi4lite_regbank dut (
        .clk(clk), .reset(reset),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .reg_q(reg_q), .wr_pulse(wr_pulse)
    );

    always #5 clk = !clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        nchk++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mdl_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (a < 32)
            for (int k = 0; k < 4; k++)
                if (s[k]) exp_q[32*a[4:2] + 8*k +: 8] = d[8*k +: 8];
    endtask

    task automatic wr_same(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
        cyc();
        awvalid = 0; wvalid = 0;
        mdl_wr(a, d, s);
    endtask

    initial begin
        cyc(); cyc();
        reset = 0;
        cyc();
        chk("rst_ready", {awready, wready, arready}, 3'b111);
        chk("rst_valid", {bvalid, rvalid, bresp, rresp}, 6'b0);
        chk("rst_regs", reg_q, '0);
        chk("rst_pulse", wr_pulse, 8'h0);
        chk("rst_rdata", rdata, 32'h0);
        // same-cycle AW+W
        wr_same(32'h04, 32'hDEADBEEF, 4'hF);
        chk("t1_bvalid", {bvalid, bresp}, 3'b100);
        chk("t1_reg1", reg_q[63:32], 32'hDEADBEEF);
        chk("t1_pulse", wr_pulse, 8'b0000_0010);
        cyc();
        chk("t1_bdrop", bvalid, 1'b0);
        chk("t1_pulse_off", wr_pulse, 8'h0);
        // W three cycles ahead of AW, partial strobes
        wr_same(32'h08, 32'hFFFFFFFF, 4'hF);
        cyc();
        wdata = 32'h11223344; wstrb = 4'b0101; wvalid = 1;
        cyc();
        wvalid = 0; wdata = 0;
        chk("t2_wheld", {wready, awready, bvalid}, 3'b010);
        cyc(); cyc();
        awaddr = 32'h08; awvalid = 1;
        cyc();
        awvalid = 0;
        mdl_wr(32'h08, 32'h11223344, 4'b0101);
        chk("t2_reg2", reg_q[95:64], 32'hFF22FF44);
        chk("t2_regs", reg_q, exp_q);
        nb = int'(bvalid);
        for (int i = 0; i < 4; i++) begin cyc(); nb += int'(bvalid); end
        chk("t2_one_b", nb, 1);
        // back-pressured B channel
        bready = 0;
        wr_same(32'h10, 32'h12345678, 4'hF);
        awaddr = 32'h14; wdata = 32'h0000CAFE; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        for (int i = 0; i < 5; i++) begin
            chk("t3_stall", {bvalid, bresp, awready, wready}, 5'b10000);
            cyc();
        end
        chk("t3_reg5_old", reg_q[191:160], 32'h0);
        bready = 1;
        cyc();
        chk("t3_accept", {bvalid, awready, wready}, 3'b011);
        cyc();
        awvalid = 0; wvalid = 0;
        mdl_wr(32'h14, 32'h0000CAFE, 4'hF);
        chk("t3_b2", bvalid, 1'b1);
        chk("t3_regs", reg_q, exp_q);
        cyc();
        // zero strobes still commit and pulse
        wr_same(32'h04, 32'hFFFFFFFF, 4'h0);
        chk("t_z_b", {bvalid, bresp}, 3'b100);
        chk("t_z_pulse", wr_pulse, 8'b0000_0010);
        chk("t_z_regs", reg_q, exp_q);
        cyc();
        // read with R back-pressure
        rready = 0; araddr = 32'h04; arvalid = 1;
        chk("t4_arready", arready, 1'b1);
        cyc();
        arvalid = 0;
        for (int i = 0; i < 3; i++) begin
            chk("t4_hold", {rvalid, arready, rresp, rdata}, {1'b1, 1'b0, 2'b00, 32'hDEADBEEF});
            cyc();
        end
        rready = 1;
        chk("t4_last", {rvalid, arready, rdata}, {2'b10, 32'hDEADBEEF});
        cyc();
        chk("t4_drop", {rvalid, arready}, 2'b01);
        // same-edge read and write of one register
        araddr = 32'h0C; arvalid = 1;
        wr_same(32'h0C, 32'h5A5A5A5A, 4'hF);
        arvalid = 0;
        chk("t5_old", {rvalid, rdata}, {1'b1, 32'h0});
        chk("t5_reg3", reg_q[127:96], 32'h5A5A5A5A);
        cyc();
        arvalid = 1;
        cyc();
        arvalid = 0;
        chk("t5_new", {rvalid, rdata}, {1'b1, 32'h5A5A5A5A});
        cyc();
        // out-of-range access
        wr_same(32'h40, 32'hFFFFFFFF, 4'hF);
        chk("t6_bresp", {bvalid, bresp}, {1'b1, ERR});
        chk("t6_pulse", wr_pulse, 8'h0);
        chk("t6_regs", reg_q, exp_q);
        araddr = 32'h40; arvalid = 1;
        cyc();
        arvalid = 0;
        chk("t6_read", {rvalid, rresp, rdata}, {1'b1, ERR, 32'h0});
        cyc();
        // reset drops a half-complete write
        wdata = 32'h77; wstrb = 4'hF; wvalid = 1;
        cyc();
        wvalid = 0;
        reset = 1;
        cyc();
        reset = 0;
        chk("t7_regs", reg_q, '0);
        chk("t7_ready", {awready, wready, bvalid, rvalid}, 4'b1100);
        awaddr = 32'h1C; awvalid = 1;
        cyc();
        awvalid = 0;
        chk("t7_nob", {bvalid, awready, wr_pulse}, 10'b0);
        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end
endmodule
